// File: rtl/video_pixel_fetch.sv
// video_pixel_fetch: drains a first-word-fall-through pixel FIFO towards the
// display timing generator. Each data_req is answered with pixel_data one
// cycle later. Every vertical sync flushes the FIFO, requests a fresh frame
// from the DDR reader and waits for a pre-fill level before serving.
// Underflowed requests get BLANK_RGB and set a sticky flag.
//
// Optional feature macro: VIDEO_PIXEL_FETCH_STATS_EN enables underflow_cnt
// and frame_cnt; without it both are tied to zero.
//
// Ports:
//   pixel_clk      in   pixel clock
//   sys_rst        in   asynchronous active-high reset
//   video_vs       in   vertical sync, active low
//   data_req       in   pixel request, one cycle ahead of video_de
//   pixel_data     out  registered pixel to the timing generator
//   fifo_dout      in   FWFT FIFO head word
//   fifo_empty     in   FIFO empty
//   fifo_rd_count  in   FIFO fill level
//   fifo_rd_en     out  FIFO pop (combinational)
//   frame_req      out  one-cycle pulse: restart DDR reader at frame base
//   underflow      out  sticky underflow flag
//   underflow_cnt  out  saturating count of underflowed requests
//   frame_cnt      out  wrapping count of frames entering RUN
module video_pixel_fetch #(
  parameter int unsigned        DATA_W    = 24,
  parameter int unsigned        CNT_W     = 11,
  parameter int unsigned        PREFILL   = 64,
  parameter logic [DATA_W-1:0]  BLANK_RGB = '0
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              video_vs,
  input  logic              data_req,
  output logic [DATA_W-1:0] pixel_data,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_rd_count,
  output logic              fifo_rd_en,
  output logic              frame_req,
  output logic              underflow,
  output logic [15:0]       underflow_cnt,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    FLUSH   = 2'd1,
    PRIME   = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   vs_d;
  logic   vs_fall;
  logic   frame_req_next;
  logic   serve;
  logic   uf_event;

  assign vs_fall  = vs_d & ~video_vs;
  // A request is served only from a non-empty FIFO while running.
  assign serve    = data_req & (state == RUN) & ~fifo_empty;
  assign uf_event = data_req & ~serve;

  // State, sync edge detector and registered outputs.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= WAIT_VS;
      vs_d       <= 1'b1;
      frame_req  <= 1'b0;
      pixel_data <= BLANK_RGB;
      underflow  <= 1'b0;
    end else begin
      state     <= state_next;
      vs_d      <= video_vs;
      frame_req <= frame_req_next;
      if (data_req) begin
        pixel_data <= serve ? fifo_dout : BLANK_RGB;
      end
      if (uf_event) begin
        underflow <= 1'b1;
      end
    end
  end

  // Next state, frame request and FIFO pop.
  always_comb begin
    state_next     = state;
    frame_req_next = 1'b0;
    fifo_rd_en     = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vs_fall) state_next = FLUSH;
      end
      FLUSH: begin
        // Sync edges are ignored here; the flush simply continues.
        fifo_rd_en = ~fifo_empty;
        if (fifo_empty) begin
          frame_req_next = 1'b1;
          state_next     = PRIME;
        end
      end
      PRIME: begin
        if (vs_fall) begin
          state_next = FLUSH;
        end else if (fifo_rd_count >= CNT_W'(PREFILL)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A coincident request is still served before restarting.
        fifo_rd_en = serve;
        if (vs_fall) state_next = FLUSH;
      end
      default: begin
        state_next = WAIT_VS;
      end
    endcase
  end

`ifdef VIDEO_PIXEL_FETCH_STATS_EN
  logic prime_done;
  assign prime_done = (state == PRIME) && (state_next == RUN);

  // Statistics: saturating underflow count, wrapping frame count.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      underflow_cnt <= '0;
      frame_cnt     <= '0;
    end else begin
      if (uf_event && (underflow_cnt != '1)) begin
        underflow_cnt <= underflow_cnt + STAT_W'(1);
      end
      if (prime_done) begin
        frame_cnt <= frame_cnt + STAT_W'(1);
      end
    end
  end
`else
  assign underflow_cnt = STAT_W'(0);
  assign frame_cnt     = STAT_W'(0);
`endif

endmodule

// File: tb/tb_video_pixel_fetch.sv
// Self-checking bench for video_pixel_fetch: a queue-based FWFT FIFO model,
// directed startup/steady-state sequences, a table of underflow vectors and
// hand-written corner cases (prime-level boundary, vsync during a request,
// asynchronous reset mid-frame). Counter expectations follow the build macro.
module tb_video_pixel_fetch;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned PREFILL = 64;
  localparam logic [DATA_W-1:0] BLANK = 24'h5A5A5A;

`ifdef VIDEO_PIXEL_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              pixel_clk = 1'b0;
  logic              sys_rst   = 1'b1;
  logic              video_vs  = 1'b1;
  logic              data_req  = 1'b0;
  logic [DATA_W-1:0] pixel_data;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_empty = 1'b1;
  logic [CNT_W-1:0]  fifo_rd_count = '0;
  logic              fifo_rd_en;
  logic              frame_req;
  logic              underflow;
  logic [15:0]       underflow_cnt;
  logic [15:0]       frame_cnt;

  video_pixel_fetch #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .PREFILL(PREFILL), .BLANK_RGB(BLANK)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(video_vs),
    .data_req(data_req), .pixel_data(pixel_data), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
    .fifo_rd_en(fifo_rd_en), .frame_req(frame_req), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  // FIFO model: pop on rd_en, then apply any pending push batch.
  logic [DATA_W-1:0] q[$];
  int                push_n = 0;
  logic [DATA_W-1:0] push_base = '0;
  int                push_tag = 0;
  int                seen_tag = 0;
  int                pops = 0;
  int                bad_pops = 0;
  int                fr_seen = 0;

  always @(posedge pixel_clk) begin
    if (fifo_rd_en) begin
      if (q.size() == 0) bad_pops++;
      else begin
        void'(q.pop_front());
        pops++;
      end
    end
    if (push_tag != seen_tag) begin
      seen_tag = push_tag;
      for (int i = 0; i < push_n; i++) q.push_back(push_base + DATA_W'(i));
    end
    if (frame_req) fr_seen++;
    fifo_empty    <= (q.size() == 0);
    fifo_rd_count <= CNT_W'(q.size());
    fifo_dout     <= (q.size() != 0) ? q[0] : '0;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic push(input int n, input logic [DATA_W-1:0] base);
    push_n    = n;
    push_base = base;
    push_tag++;
    tick(1);
  endtask

  task automatic wait_frame_req(input string name, input int budget);
    int n = 0;
    while (!frame_req && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(frame_req), 32'd1);
  endtask

  typedef struct {
    int unsigned       preload;
    int unsigned       reqs;
    logic [DATA_W-1:0] base;
    int unsigned       exp_pops;
    int unsigned       exp_uf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p0;
    int bad;
    int uf_total;
    logic [DATA_W-1:0] e;

    vecs[0] = '{preload: 5,   reqs: 5,   base: 24'h000300, exp_pops: 5,   exp_uf: 0};
    vecs[1] = '{preload: 100, reqs: 200, base: 24'h000400, exp_pops: 100, exp_uf: 100};
    vecs[2] = '{preload: 0,   reqs: 3,   base: 24'h000500, exp_pops: 0,   exp_uf: 3};
    vecs[3] = '{preload: 1,   reqs: 2,   base: 24'h000600, exp_pops: 1,   exp_uf: 1};

    // Reset with 10 stale words already in the FIFO.
    tick(1);
    push(10, 24'h00AA00);
    check("rst_pixel", 32'(pixel_data), 32'(BLANK));
    check("rst_frame_req", 32'(frame_req), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst = 1'b0;
    tick(4);
    check("no_pop_wait_vs", 32'(pops), 32'd0);

    // Sync edge: flush the stale words, then one frame request.
    video_vs = 1'b0;
    tick(3);
    video_vs = 1'b1;
    wait_frame_req("startup_frame_req", 40);
    check("startup_flush_pops", 32'(pops), 32'd10);
    tick(1);
    check("startup_frame_req_pulse", 32'(frame_req), 32'd0);
    check("startup_frame_req_once", 32'(fr_seen), 32'd1);

    // Pre-fill with 1920 incrementing words, then a full-line burst.
    push(1920, 24'h000001);
    tick(2);
    check("startup_frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
    p0 = pops;
    bad = 0;
    for (int i = 0; i < 1920; i++) begin
      data_req = 1'b1;
      tick(1);
      if (pixel_data !== DATA_W'(i + 1)) bad++;
    end
    data_req = 1'b0;
    check("steady_data", 32'(bad), 32'd0);
    check("steady_pops", 32'(pops - p0), 32'd1920);
    check("steady_underflow", 32'(underflow), 32'd0);
    tick(3);
    check("steady_hold", 32'(pixel_data), 32'd1920);

    // Underflow vectors in RUN.
    uf_total = 0;
    for (int r = 0; r < 4; r++) begin
      if (vecs[r].preload != 0) push(int'(vecs[r].preload), vecs[r].base);
      tick(2);
      p0 = pops;
      bad = 0;
      for (int i = 0; i < int'(vecs[r].reqs); i++) begin
        data_req = 1'b1;
        tick(1);
        e = (i < int'(vecs[r].preload)) ? vecs[r].base + DATA_W'(i) : BLANK;
        if (pixel_data !== e) bad++;
      end
      data_req = 1'b0;
      tick(1);
      uf_total += int'(vecs[r].exp_uf);
      check($sformatf("vec%0d_data", r), 32'(bad), 32'd0);
      check($sformatf("vec%0d_pops", r), 32'(pops - p0), vecs[r].exp_pops);
      check($sformatf("vec%0d_underflow", r), 32'(underflow), (uf_total > 0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_uf_cnt", r), 32'(underflow_cnt), STATS ? 32'(uf_total) : 32'd0);
    end

    // Sync edge coincident with a request: served, then 300 flush pops.
    push(301, 24'h001000);
    tick(2);
    p0 = pops;
    data_req = 1'b1;
    video_vs = 1'b0;
    tick(1);
    data_req = 1'b0;
    check("vs_coincident_data", 32'(pixel_data), 32'h001000);
    tick(2);
    video_vs = 1'b1;
    wait_frame_req("midframe_frame_req", 400);
    check("midframe_pops", 32'(pops - p0), 32'd301);

    // Level one short of the threshold: requests are blanked, no pops.
    push(63, 24'h002000);
    tick(3);
    p0 = pops;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      data_req = 1'b1;
      tick(1);
      if (pixel_data !== BLANK) bad++;
    end
    data_req = 1'b0;
    uf_total += 5;
    check("prime_req_data", 32'(bad), 32'd0);
    check("prime_req_pops", 32'(pops - p0), 32'd0);
    check("prime_uf_cnt", 32'(underflow_cnt), STATS ? 32'(uf_total) : 32'd0);
    check("frame_req_total", 32'(fr_seen), 32'd2);

    // Reaching the threshold starts the frame at the first new word.
    push(1, 24'h00203F);
    tick(2);
    check("reprime_frame_cnt", 32'(frame_cnt), STATS ? 32'd2 : 32'd0);
    data_req = 1'b1;
    tick(1);
    data_req = 1'b0;
    check("reprime_first_pixel", 32'(pixel_data), 32'h002000);

    // Asynchronous reset while a request is popping.
    data_req = 1'b1;
    #2;
    check("pre_reset_rd_en", 32'(fifo_rd_en), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("async_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("async_rst_pixel", 32'(pixel_data), 32'(BLANK));
    check("async_rst_underflow", 32'(underflow), 32'd0);
    check("async_rst_uf_cnt", 32'(underflow_cnt), 32'd0);
    check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    data_req = 1'b0;
    tick(2);
    sys_rst = 1'b0;
    tick(2);
    check("pop_while_empty", 32'(bad_pops), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
